// File: rtl/vga_graph_pkg.sv
// ---------------------------------------------------------------------------
// vga_graph_pkg
//   Shared constants and types for the VGA bar-graph sample path.
//   N_SAMPLES : samples per frame, one per visible pixel column
//   DW        : sample width in bits (bar height in pixels)
//   BAR_MAX   : tallest bar that still fits under the top of the screen
//   RD_AW     : width of the pixel-column address coming from vga_sync
//   buf_state_t : fill state of the back bank (FILL / FULL)
// ---------------------------------------------------------------------------
package vga_graph_pkg;

  localparam int N_SAMPLES = 640;
  localparam int DW        = 8;
  localparam int BAR_MAX   = 239;
  localparam int RD_AW     = 10;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } buf_state_t;

endpackage

// File: rtl/sample_ram.sv
// ---------------------------------------------------------------------------
// sample_ram
//   One sample bank: simple dual-port memory, one synchronous write port and
//   one synchronous read port. Contents are deliberately not reset.
//   Ports:
//     clk     in   clock, rising edge
//     we      in   write enable
//     wr_addr in   write address
//     wr_data in   write data
//     rd_addr in   read address
//     rd_data out  read data, valid one cycle after rd_addr
// ---------------------------------------------------------------------------
module sample_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port, registered.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/graph_sample_buf.sv
// ---------------------------------------------------------------------------
// graph_sample_buf
//   Double-buffered sample store for a VGA bar graph. A producer fills the
//   back bank; the front bank is read by pixel column. A completely filled
//   back bank is promoted to front on the next vsync_n falling edge, so the
//   display never shows a partially written frame.
//
//   Optional build macro SAMPLE_CLAMP_EN: when defined, samples are clamped
//   to BAR_MAX before storage; otherwise stored unmodified.
//
//   Ports:
//     clk      in   system clock, rising edge
//     _rst     in   asynchronous active-low reset
//     wr_valid in   producer has a sample
//     wr_data  in   sample value
//     wr_ready out  buffer accepts a sample (back bank filling)
//     vsync_n  in   active-low vertical sync
//     rd_addr  in   pixel column
//     rd_data  out  front-bank sample for rd_addr, one cycle later
//     swap     out  one-cycle pulse when the banks swap
// ---------------------------------------------------------------------------
module graph_sample_buf #(
  parameter int N_SAMPLES = vga_graph_pkg::N_SAMPLES,
  parameter int DW        = vga_graph_pkg::DW
) (
  input  logic                           clk,
  input  logic                           _rst,
  input  logic                           wr_valid,
  input  logic [DW-1:0]                  wr_data,
  output logic                           wr_ready,
  input  logic                           vsync_n,
  input  logic [vga_graph_pkg::RD_AW-1:0] rd_addr,
  output logic [DW-1:0]                  rd_data,
  output logic                           swap
);

  import vga_graph_pkg::*;

  localparam int            AW       = $clog2(N_SAMPLES);
  localparam logic [AW-1:0] LAST_PTR = AW'(N_SAMPLES - 1);

  buf_state_t    state;
  buf_state_t    state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic          front_sel;
  logic          front_sel_nxt;
  logic          front_valid;
  logic          front_valid_nxt;
  logic          swap_nxt;
  logic          vs_q;
  logic          vs_fall;
  logic          wr_accept;
  logic [DW-1:0] wr_sample;
  logic          we0;
  logic          we1;
  logic          rd_in_range;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;
  logic          rd_sel_q;
  logic          rd_ok_q;

  assign wr_ready  = (state == FILL);
  assign wr_accept = wr_valid & wr_ready;
  assign vs_fall   = vs_q & ~vsync_n;

  // Sample conditioning before storage.
  always_comb begin
    wr_sample = wr_data;
`ifdef SAMPLE_CLAMP_EN
    if (wr_data > DW'(BAR_MAX)) begin
      wr_sample = DW'(BAR_MAX);
    end else begin
      wr_sample = wr_data;
    end
`endif
  end

  // Fill/swap next-state logic. A vs_fall seen while still in FILL (even on
  // the very cycle of the last write) is ignored: the swap waits for the
  // next frame boundary so the new frame is always shown whole.
  always_comb begin
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    front_sel_nxt   = front_sel;
    front_valid_nxt = front_valid;
    swap_nxt        = 1'b0;
    case (state)
      FILL: begin
        if (wr_accept) begin
          if (wr_ptr == LAST_PTR) begin
            // Pointer parks on the last slot; it is cleared at the swap.
            state_nxt = FULL;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end else begin
          state_nxt = FILL;
        end
      end
      FULL: begin
        if (vs_fall) begin
          state_nxt       = FILL;
          wr_ptr_nxt      = '0;
          front_sel_nxt   = ~front_sel;
          front_valid_nxt = 1'b1;
          swap_nxt        = 1'b1;
        end else begin
          state_nxt = FULL;
        end
      end
      default: begin
        state_nxt  = FILL;
        wr_ptr_nxt = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      vs_q        <= 1'b1;
      swap        <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      front_sel   <= front_sel_nxt;
      front_valid <= front_valid_nxt;
      vs_q        <= vsync_n;
      swap        <= swap_nxt;
    end
  end

  // Bank 0 is front when front_sel=0, so writes go to the other bank.
  assign we0 = wr_accept &  front_sel;
  assign we1 = wr_accept & ~front_sel;

  assign rd_in_range = (rd_addr < vga_graph_pkg::RD_AW'(N_SAMPLES));
  assign ram_rd_addr = rd_in_range ? rd_addr[AW-1:0] : '0;

  sample_ram #(
    .DEPTH (N_SAMPLES),
    .DW    (DW),
    .AW    (AW)
  ) u_bank0 (
    .clk     (clk),
    .we      (we0),
    .wr_addr (wr_ptr),
    .wr_data (wr_sample),
    .rd_addr (ram_rd_addr),
    .rd_data (q0)
  );

  sample_ram #(
    .DEPTH (N_SAMPLES),
    .DW    (DW),
    .AW    (AW)
  ) u_bank1 (
    .clk     (clk),
    .we      (we1),
    .wr_addr (wr_ptr),
    .wr_data (wr_sample),
    .rd_addr (ram_rd_addr),
    .rd_data (q1)
  );

  // Read-side qualifiers, aligned with the RAM read latency. Because these
  // carry the reset, rd_data drops to zero asynchronously on _rst even
  // though the RAM output registers themselves are not reset.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      rd_sel_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      rd_sel_q <= front_sel;
      rd_ok_q  <= rd_in_range & front_valid;
    end
  end

  // Front-bank select and blanking of out-of-range / not-yet-valid reads.
  always_comb begin
    rd_data = '0;
    if (rd_ok_q) begin
      rd_data = rd_sel_q ? q1 : q0;
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: tb/tb_graph_sample_buf.sv
module tb_graph_sample_buf;

  localparam int N = 640;

  logic       clk = 1'b0;
  logic       _rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       vsync_n;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       swap;

  always #5 clk = ~clk;

  graph_sample_buf dut (
    .clk      (clk),
    ._rst     (_rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .vsync_n  (vsync_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .swap     (swap)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: the frame being collected, the frame on display.
  logic [7:0] fill_q[$];
  logic [7:0] disp[N];
  bit         disp_valid = 1'b0;
  bit         vs_prev    = 1'b1;
  bit         exp_swap   = 1'b0;
  logic [7:0] exp_rd     = 8'd0;

  function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef SAMPLE_CLAMP_EN
    return (v > 8'd239) ? 8'd239 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic exp_ready();
    return (fill_q.size() < N);
  endfunction

  // One clock: drive inputs, advance the model, settle 1ns after the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic vs, input logic [9:0] ra);
    bit acc;
    bit fall;
    bit swp;
    wr_valid = v;
    wr_data  = d;
    vsync_n  = vs;
    rd_addr  = ra;
    acc  = v && (fill_q.size() < N);
    fall = vs_prev && !vs;
    swp  = fall && (fill_q.size() == N);
    exp_rd = (disp_valid && (ra < 10'd640)) ? disp[ra] : 8'd0;
    @(posedge clk);
    if (swp) begin
      for (int i = 0; i < N; i++) disp[i] = fill_q[i];
      disp_valid = 1'b1;
      fill_q.delete();
    end
    if (acc) fill_q.push_back(stored(d));
    vs_prev  = vs;
    exp_swap = swp;
    #1;
  endtask

  // Push n samples with random idle gaps; modpat selects value = index mod 200.
  task automatic fill_samples(input int n, input bit modpat);
    int         done;
    bit         v;
    logic [7:0] d;
    done = 0;
    while (done < n) begin
      v = ($urandom_range(0, 3) != 0);
      d = modpat ? 8'(fill_q.size() % 200) : 8'($urandom_range(0, 255));
      if (v) done++;
      tick(v, d, 1'b1, 10'($urandom_range(0, 1023)));
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    disp_valid = 1'b0;
    vs_prev    = 1'b1;
    exp_swap   = 1'b0;
  endtask

  task automatic test_reset();
    _rst = 1'b0; wr_valid = 1'b0; wr_data = 8'd0; vsync_n = 1'b1; rd_addr = 10'd0;
    model_reset();
    #3;
    total_cnt++;
    if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready);
    else pass_cnt++;
    total_cnt++;
    if (swap !== 1'b0) $display("FAIL reset_swap: got %0b expected 0", swap);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'd0) $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
    else pass_cnt++;
    _rst = 1'b1;
    for (int a = 0; a < N; a++) begin
      tick(1'b0, 8'd0, 1'b1, 10'(a));
      total_cnt++;
      if (rd_data !== exp_rd) $display("FAIL reset_sweep addr %0d: got %0d expected %0d", a, rd_data, exp_rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_full_frame();
    fill_samples(N, 1'b1);
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL full_wr_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b1, 8'd77, 1'b1, 10'd0);
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL extra_write_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b0, 10'd5);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL full_swap_pulse: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd5);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL full_swap_end: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL full_rd5: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL full_refill_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    for (int a = 0; a < N; a++) begin
      tick(1'b0, 8'd0, 1'b1, 10'(a));
      total_cnt++;
      if (rd_data !== exp_rd) $display("FAIL full_sweep addr %0d: got %0d expected %0d", a, rd_data, exp_rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_partial_vsync();
    logic [9:0] ra;
    fill_samples(300, 1'b0);
    tick(1'b0, 8'd0, 1'b0, 10'd7);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL partial_no_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL partial_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd7);
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL partial_front_kept: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
    // Keep filling while reading the front bank at random columns.
    for (int k = 0; k < 340; k++) begin
      ra = 10'($urandom_range(0, N - 1));
      tick(1'b1, 8'($urandom_range(0, 255)), 1'b1, ra);
      total_cnt++;
      if (rd_data !== exp_rd) $display("FAIL partial_read addr %0d: got %0d expected %0d", ra, rd_data, exp_rd);
      else pass_cnt++;
    end
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL partial_full_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b0, 10'd0);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL partial_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd0);
    for (int a = 0; a < N; a++) begin
      tick(1'b0, 8'd0, 1'b1, 10'(a));
      total_cnt++;
      if (rd_data !== exp_rd) $display("FAIL partial_sweep addr %0d: got %0d expected %0d", a, rd_data, exp_rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_final_write_vsync();
    fill_samples(N - 1, 1'b0);
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL final_ready_before: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 10'd3);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL final_same_cycle_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL final_ready_after: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd3);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL final_idle_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL final_front_kept: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b0, 10'd3);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL final_next_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd3);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL final_swap_one_cycle: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL final_new_front: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_range_and_clamp();
    logic [7:0] want0;
`ifdef SAMPLE_CLAMP_EN
    want0 = 8'd239;
`else
    want0 = 8'd250;
`endif
    tick(1'b1, 8'd250, 1'b1, 10'd0);
    fill_samples(N - 1, 1'b0);
    tick(1'b0, 8'd0, 1'b0, 10'd640);
    tick(1'b0, 8'd0, 1'b1, 10'd640);
    total_cnt++;
    if (rd_data !== 8'd0) $display("FAIL range_640: got %0d expected 0", rd_data);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd1023);
    total_cnt++;
    if (rd_data !== 8'd0) $display("FAIL range_1023: got %0d expected 0", rd_data);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd0);
    total_cnt++;
    if (rd_data !== want0) $display("FAIL clamp_250: got %0d expected %0d", rd_data, want0);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL clamp_model: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_midfill();
    fill_samples(100, 1'b0);
    tick(1'b0, 8'd0, 1'b1, 10'd5);
    _rst = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (rd_data !== 8'd0) $display("FAIL midreset_rd_data: got %0d expected 0", rd_data);
    else pass_cnt++;
    total_cnt++;
    if (wr_ready !== 1'b1) $display("FAIL midreset_ready: got %0b expected 1", wr_ready);
    else pass_cnt++;
    total_cnt++;
    if (swap !== 1'b0) $display("FAIL midreset_swap: got %0b expected 0", swap);
    else pass_cnt++;
    #2;
    _rst = 1'b1;
    tick(1'b0, 8'd0, 1'b0, 10'd5);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL midreset_vs_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd5);
    total_cnt++;
    if (rd_data !== exp_rd) $display("FAIL midreset_read: got %0d expected %0d", rd_data, exp_rd);
    else pass_cnt++;
    fill_samples(N, 1'b0);
    total_cnt++;
    if (wr_ready !== exp_ready()) $display("FAIL refill_ready: got %0b expected %0b", wr_ready, exp_ready());
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b0, 10'd0);
    total_cnt++;
    if (swap !== exp_swap) $display("FAIL refill_swap: got %0b expected %0b", swap, exp_swap);
    else pass_cnt++;
    tick(1'b0, 8'd0, 1'b1, 10'd0);
    for (int a = 0; a < N; a++) begin
      tick(1'b0, 8'd0, 1'b1, 10'(a));
      total_cnt++;
      if (rd_data !== exp_rd) $display("FAIL refill_sweep addr %0d: got %0d expected %0d", a, rd_data, exp_rd);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_vsync();
    test_final_write_vsync();
    test_range_and_clamp();
    test_reset_midfill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/graph_sample_buf.md
GRAPH_SAMPLE_BUF -- requirements
Module: graph_sample_buf

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 640, number of samples per frame (one per pixel column).
REQ-002 SHALL have parameter DW, default 8, sample width in bits.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port _rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  producer has a sample.
REQ-006 SHALL have port wr_data  input  DW  sample value (bar height in pixels).
REQ-007 SHALL have port wr_ready  output  1  buffer accepts a sample.
REQ-008 SHALL have port vsync_n  input  1  active-low vertical sync from vga_sync.
REQ-009 SHALL have port rd_addr  input  10  pixel column (pixel_x).
REQ-010 SHALL have port rd_data  output  DW  sample for rd_addr.
REQ-011 SHALL have port swap  output  1  one-cycle pulse when buffers swap.

Function
REQ-012 SHALL hold two banks of N_SAMPLES x DW: front (read), back (write); front_sel selects the front bank.
REQ-013 SHALL accept a write when wr_valid & wr_ready: back[wr_ptr] <= sample, wr_ptr <= wr_ptr+1.
REQ-014 SHALL implement states FILL and FULL; wr_ready = (state==FILL), combinational from state.
REQ-015 SHALL go FILL->FULL on the accepted write at wr_ptr==N_SAMPLES-1; wr_ptr SHALL not wrap past N_SAMPLES-1.
REQ-016 SHALL detect the frame boundary as the vsync_n falling edge, using a registered copy of vsync_n (vs_fall = vs_q & ~vsync_n).
REQ-017 SHALL, on vs_fall in FULL: toggle front_sel, clear wr_ptr, enter FILL, set front_valid, and pulse swap for exactly one cycle.
REQ-018 SHALL ignore vs_fall in FILL; front bank unchanged, filling continues.
REQ-019 SHALL treat a vs_fall in the same cycle as the final write as occurring in FILL; the swap SHALL wait for the next vs_fall.
REQ-020 SHALL register rd_data one cycle after rd_addr from the front bank.
REQ-021 SHALL drive rd_data = 0 when rd_addr >= N_SAMPLES or front_valid==0.
REQ-022 SHALL never present partially written back-bank data on rd_data.

Reset
REQ-023 SHALL, on _rst low, asynchronously set state=FILL, wr_ptr=0, front_sel=0, front_valid=0, vs_q=1, swap=0, rd_data=0; wr_ready=1.
REQ-024 SHALL not reset bank contents; reset mid-fill discards the partial frame.

Configuration
REQ-025 SHALL, with macro SAMPLE_CLAMP_EN defined, store min(wr_data, BAR_MAX) with BAR_MAX=239, so a bar never crosses the top of the screen.
REQ-026 SHALL, without SAMPLE_CLAMP_EN, store wr_data unmodified.

Structure
REQ-027 SHALL take N_SAMPLES, DW, BAR_MAX and the FILL/FULL state encoding from shared package vga_graph_pkg.
REQ-028 SHALL instantiate each bank as sub-module sample_ram: one synchronous write port and one synchronous read port, no reset.

Verification
REQ-029 After reset, rd_addr=0..639 -> rd_data=0; wr_ready=1; swap=0.
REQ-030 Write 640 samples (value = addr mod 200) -> wr_ready=0 after the 640th write; a 641st wr_valid is not accepted; then vs_fall -> single swap pulse; next frame rd_addr=5 -> rd_data=5 one cycle later.
REQ-031 Write 300 samples, then vs_fall -> no swap, front unchanged, wr_ready stays 1; remaining 340 writes, then vs_fall -> swap.
REQ-032 Final write and vs_fall in the same cycle -> no swap; swap on the following vs_fall.
REQ-033 rd_addr=640 and 1023 -> rd_data=0; with SAMPLE_CLAMP_EN, writing 250 -> reads 239, and without it reads 250.
REQ-034 Assert _rst after 100 writes -> wr_ptr=0, front_valid=0, rd_data=0 immediately; refill of 640 samples plus vs_fall restores normal swap.
